// File: rtl/shift_chain_pkg.sv
// Shared types and constants for the multi-word shift sequencer.
package shift_chain_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    LOAD,
    CMD,
    SHIFT,
    DRAIN
  } state_e;

  // LSL walks words upward from word 0; every other op walks down from the top word.
  function automatic logic op_is_left(op_e op);
    return op == OP_LSL;
  endfunction

endpackage

// File: rtl/shift_chain_word.sv
// Combinational 1-bit shift of a single word with explicit fill and ejected bit.
module shift_chain_word #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             fill_i,
  input  logic             dir_i,    // 1: right, 0: left
  output logic [WIDTH-1:0] word_o,
  output logic             eject_o
);

  always_comb begin
    if (dir_i) begin
      word_o  = {fill_i, word_i[WIDTH-1:1]};
      eject_o = word_i[0];
    end else begin
      word_o  = {word_i[WIDTH-2:0], fill_i};
      eject_o = word_i[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_chain_seq.sv
// Multi-word shift sequencer: load WORDS words, shift the whole value one word per cycle,
// read it back. Define SHIFT_CHAIN_CARRY_EN to make ROR rotate through a carry bit.
module shift_chain_seq
  import shift_chain_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_WIDTH-1:0] ld_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_W-1:0]     cmd_cnt,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [REG_WIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 busy,
  input  logic                 sftin,
  output logic                 sftout
);

  localparam int unsigned      PTR_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ld_ptr_q, ld_ptr_d;
  logic [PTR_W-1:0]     wd_ptr_q, wd_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  op_e                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 prime_q, prime_d;
  logic                 fill_q, fill_d;
  logic                 sftout_q, sftout_d;
  logic [REG_WIDTH-1:0] word_q [WORDS];
  logic [REG_WIDTH-1:0] word_d [WORDS];
`ifdef SHIFT_CHAIN_CARRY_EN
  logic                 carry_q, carry_d;
`else
  logic                 unused_sftin;
  assign unused_sftin = sftin;
`endif

  logic                 ld_acc, cmd_acc, rd_acc;
  logic [PTR_W-1:0]     start_ptr, end_ptr;
  logic                 pass_first, pass_last, pass_fill;
  logic [REG_WIDTH-1:0] sh_in, sh_out;
  logic                 sh_fill, sh_eject, sh_right;

  assign ld_acc  = ld_valid & ld_ready;
  assign cmd_acc = cmd_valid & cmd_ready;
  assign rd_acc  = rd_valid & rd_ready;

  // Pass geometry and the fill bit entering the first word of each pass.
  always_comb begin
    start_ptr  = op_is_left(op_q) ? '0 : LAST_PTR;
    end_ptr    = op_is_left(op_q) ? LAST_PTR : '0;
    pass_first = (wd_ptr_q == start_ptr);
    pass_last  = (wd_ptr_q == end_ptr);
    unique case (op_q)
      OP_LSL:  pass_fill = 1'b0;
      OP_LSR:  pass_fill = 1'b0;
      OP_ASR:  pass_fill = word_q[WORDS-1][REG_WIDTH-1];
`ifdef SHIFT_CHAIN_CARRY_EN
      OP_ROR:  pass_fill = carry_q;
`else
      // Word 0 is processed last in a right pass, so it still holds its pass-start value.
      OP_ROR:  pass_fill = word_q[0][0];
`endif
      default: pass_fill = 1'b0;
    endcase
    sh_in    = word_q[wd_ptr_q];
    sh_fill  = pass_first ? pass_fill : fill_q;
    sh_right = !op_is_left(op_q);
  end

  shift_chain_word #(
    .WIDTH (REG_WIDTH)
  ) u_word (
    .word_i  (sh_in),
    .fill_i  (sh_fill),
    .dir_i   (sh_right),
    .word_o  (sh_out),
    .eject_o (sh_eject)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A command spends one setup cycle (prime) before any word moves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:  if (ld_acc && ld_ptr_q == LAST_PTR) state_d = CMD;
      CMD: begin
        if (prime_q) begin
          state_d = DRAIN;
        end else if (cmd_acc && cmd_cnt != '0) begin
          state_d = SHIFT;
        end
      end
      SHIFT: if (!prime_q && pass_last && cnt_q == CNT_W'(1)) state_d = DRAIN;
      DRAIN: if (rd_acc && rd_ptr_q == LAST_PTR) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Outputs.
  always_comb begin
    ld_ready  = (state_q == LOAD);
    cmd_ready = (state_q == CMD) && !prime_q;
    rd_valid  = (state_q == DRAIN);
    busy      = (state_q == SHIFT);
    rd_data   = word_q[rd_ptr_q];
    rd_last   = rd_valid && (rd_ptr_q == LAST_PTR);
    sftout    = sftout_q;
  end

  // Datapath next state.
  always_comb begin
    ld_ptr_d = ld_ptr_q;
    wd_ptr_d = wd_ptr_q;
    rd_ptr_d = rd_ptr_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    prime_d  = 1'b0;
    fill_d   = fill_q;
    sftout_d = sftout_q;
    word_d   = word_q;
`ifdef SHIFT_CHAIN_CARRY_EN
    carry_d  = carry_q;
`endif

    if (ld_acc) begin
      word_d[ld_ptr_q] = ld_data;
      ld_ptr_d = (ld_ptr_q == LAST_PTR) ? '0 : ld_ptr_q + 1'b1;
    end

    if (cmd_acc) begin
      op_d     = op_e'(cmd_op);
      cnt_d    = cmd_cnt;
      prime_d  = 1'b1;
      wd_ptr_d = op_is_left(op_e'(cmd_op)) ? '0 : LAST_PTR;
`ifdef SHIFT_CHAIN_CARRY_EN
      carry_d  = sftin;
`endif
    end

    if (state_q == SHIFT && !prime_q) begin
      word_d[wd_ptr_q] = sh_out;
      fill_d = sh_eject;
      if (pass_last) begin
        sftout_d = sh_eject;
`ifdef SHIFT_CHAIN_CARRY_EN
        if (op_q == OP_ROR) carry_d = sh_eject;
`endif
        cnt_d    = cnt_q - CNT_W'(1);
        wd_ptr_d = start_ptr;
      end else begin
        wd_ptr_d = op_is_left(op_q) ? wd_ptr_q + 1'b1 : wd_ptr_q - 1'b1;
      end
    end

    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ptr_q <= '0;
      wd_ptr_q <= '0;
      rd_ptr_q <= '0;
      op_q     <= OP_LSL;
      cnt_q    <= '0;
      prime_q  <= 1'b0;
      fill_q   <= 1'b0;
      sftout_q <= 1'b0;
`ifdef SHIFT_CHAIN_CARRY_EN
      carry_q  <= 1'b0;
`endif
      for (int i = 0; i < int'(WORDS); i++) begin
        word_q[i] <= '0;
      end
    end else begin
      ld_ptr_q <= ld_ptr_d;
      wd_ptr_q <= wd_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      prime_q  <= prime_d;
      fill_q   <= fill_d;
      sftout_q <= sftout_d;
`ifdef SHIFT_CHAIN_CARRY_EN
      carry_q  <= carry_d;
`endif
      word_q   <= word_d;
    end
  end

  ready_excl_a: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ld_ready, cmd_ready, rd_valid}));

endmodule

// File: tb/tb_shift_chain_seq.sv
// Directed, table-driven bench for shift_chain_seq with REG_WIDTH=16, WORDS=2.
module tb_shift_chain_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_ready;
  logic [15:0] ld_data;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_cnt;
  logic        rd_valid, rd_ready, rd_last;
  logic [15:0] rd_data;
  logic        busy, sftin, sftout;

  int n_checks = 0;
  int n_fail   = 0;

  shift_chain_seq #(
    .REG_WIDTH (16),
    .WORDS     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .sftin     (sftin),
    .sftout    (sftout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic        sin;
    logic [15:0] w0, w1;
    logic [15:0] e0, e1;
    logic        esft;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load2(input logic [15:0] w0, input logic [15:0] w1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = (i == 0) ? w0 : w1;
      @(posedge clk);
      #1 ld_valid = 1'b0;
    end
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [3:0] cnt,
                       input logic sin, input int exp_lat);
    int lat;
    @(negedge clk);
    check({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({name, " ld_ready in CMD"}, 32'(ld_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    sftin     = sin;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (!rd_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic read2(input string name, input logic [15:0] e0, input logic [15:0] e1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("%s rd_valid[%0d]", name, i), 32'(rd_valid), 32'd1);
      check($sformatf("%s rd_data[%0d]", name, i), 32'(rd_data), (i == 0) ? 32'(e0) : 32'(e1));
      check($sformatf("%s rd_last[%0d]", name, i), 32'(rd_last), 32'(i == 1));
      rd_ready = 1'b1;
      @(posedge clk);
      #1 rd_ready = 1'b0;
    end
    check({name, " back to LOAD"}, 32'(ld_ready), 32'd1);
    check({name, " rd_valid dropped"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             op     cnt  sin  w0        w1        e0        e1        sft   lat
    vecs[0] = '{2'b00, 4'd1, 1'b0, 16'h8001, 16'h0001, 16'h0002, 16'h0003, 1'b0, 3};
    vecs[1] = '{2'b10, 4'd4, 1'b0, 16'h0000, 16'h8000, 16'h0000, 16'hF800, 1'b0, 9};
`ifdef SHIFT_CHAIN_CARRY_EN
    vecs[2] = '{2'b11, 4'd1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3};
`else
    vecs[2] = '{2'b11, 4'd1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 1'b1, 3};
`endif
    vecs[3] = '{2'b01, 4'd3, 1'b0, 16'h1234, 16'hABCD, 16'hA246, 16'h1579, 1'b1, 7};
    vecs[4] = '{2'b00, 4'd4, 1'b0, 16'hF00F, 16'h0FF0, 16'h00F0, 16'hFF0F, 1'b0, 9};
    vecs[5] = '{2'b10, 4'd2, 1'b0, 16'h0006, 16'h4000, 16'h0001, 16'h1000, 1'b1, 5};
`ifdef SHIFT_CHAIN_CARRY_EN
    vecs[6] = '{2'b11, 4'd4, 1'b1, 16'h1234, 16'hABCD, 16'hD123, 16'h9ABC, 1'b0, 9};
`else
    vecs[6] = '{2'b11, 4'd4, 1'b1, 16'h1234, 16'hABCD, 16'hD123, 16'h4ABC, 1'b0, 9};
`endif

    rst = 1'b1;
    ld_valid = 1'b0; ld_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0;
    rd_ready = 1'b0; sftin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ld_ready", 32'(ld_ready), 32'd1);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sftout", 32'(sftout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      load2(vecs[i].w0, vecs[i].w1);
      issue(nm, vecs[i].op, vecs[i].cnt, vecs[i].sin, vecs[i].lat);
      read2(nm, vecs[i].e0, vecs[i].e1);
      check({nm, " sftout"}, 32'(sftout), 32'(vecs[i].esft));
    end

    // Reset while shifting: everything returns to LOAD at once.
    load2(16'h1111, 16'h2222);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_cnt = 4'd4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midshift busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ld_ready", 32'(ld_ready), 32'd1);
    check("midrst rd_valid", 32'(rd_valid), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst sftout", 32'(sftout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load2(16'h0003, 16'h8000);
    issue("post-reset LSR", 2'b01, 4'd1, 1'b0, 3);
    read2("post-reset LSR", 16'h0001, 16'h4000);
    check("post-reset sftout", 32'(sftout), 32'd1);

    // cnt=0 under backpressure: data untouched, sftout keeps its value.
    load2(16'h5A5A, 16'h1234);
    issue("cnt0", 2'b00, 4'd0, 1'b0, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("cnt0 hold rd_valid c%0d", c), 32'(rd_valid), 32'd1);
      check($sformatf("cnt0 hold rd_data c%0d", c), 32'(rd_data), 32'h5A5A);
      check($sformatf("cnt0 hold busy c%0d", c), 32'(busy), 32'd0);
    end
    read2("cnt0", 16'h5A5A, 16'h1234);
    check("cnt0 sftout", 32'(sftout), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
